fphub_pair_issuer: RTL and testbench
====================================

# fphub_pair_issuer

Upstream operand stage for the combinational FPHUB adder. It accepts a serial stream of FPHUB words, pairs consecutive words into X/Y operands, and applies an optional per-pair subtract by flipping Y's sign. Pairs are buffered in a small FIFO whose head drives the adder. The adder's Z is captured into a registered valid/ready output.

## Interface
- M, 23, mantissa width (matches adder)
- E, 8, exponent width (matches adder)
- DEPTH, 4, pair FIFO entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous drop of partial pair and FIFO contents
- in_valid  in  1  operand word valid
- in_ready  out  1  operand word accepted when in_valid & in_ready
- in_data  in  E+M+1  FPHUB word {sign, exp[E-1:0], mant[M-1:0]}
- in_sub  in  1  sampled with the Y word only; 1 = X − Y
- add_x  out  E+M+1  FIFO head X to adder
- add_y  out  E+M+1  FIFO head Y (sign already adjusted) to adder
- add_z  in  E+M+1  adder result, combinational from add_x/add_y
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_z  out  E+M+1  registered result
- level  out  $clog2(DEPTH)+1  FIFO occupancy in pairs

## Operation
- Pairing FSM, two states:
  - WAIT_X: an accepted word is stored in x_hold; go to WAIT_Y.
  - WAIT_Y: an accepted word forms the pair {x_hold, in_data ^ (in_sub << (E+M))}; the pair is pushed to the FIFO; go to WAIT_X.
- in_ready = !flush & !(state==WAIT_Y & fifo_full). In WAIT_X a word is always accepted, even if the FIFO is full.
- The pop-enable term is not used in in_ready, so there is no combinational path from out_ready to in_ready.
- Pop rule: pop = !empty & (!out_valid | out_ready). On pop, out_z <= add_z and out_valid <= 1.
- When out_valid & out_ready and no pop, out_valid <= 0.
- Push and pop in the same cycle: level unchanged. Push is only allowed when not full; a pop does not free a slot for a same-cycle push.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level = wr_cnt − rd_cnt, computed with an extra MSB.
- add_x/add_y always show the head entry. When empty, they show stale data and must be ignored.
- flush:
  - state <= WAIT_X; FIFO pointers cleared; level <= 0.
  - The output register is untouched: a pending out_z stays valid until taken.
  - in_ready is 0 during flush, so the word is dropped.
  - flush takes priority over push and pop in the same cycle.
- Sign handling is a bit flip only. No special-case checks: NaN/Inf/zero pass through to the adder unchanged.

## Timing
- Reset values: state=WAIT_X; pointers=0; level=0; out_valid=0; out_z=0; x_hold=0; in_ready=1 (since flush=0).
- Latency: Y accepted at edge k → pair at FIFO head after k → out_valid high after edge k+1, if the output register is free. Minimum latency is 2 cycles from the Y handshake.
- Throughput: one pair per 2 input cycles; the output sustains 1 result per cycle while draining.
- Backpressure: out_ready low holds out_z and out_valid stable. The FIFO fills, then in_ready drops in WAIT_Y.
- rst asserted mid-operation: all state clears immediately and asynchronously. Partial pairs and results are lost.

## Structure
- Shared package fphub_pkg: localparam W = E+M+1; typedef struct packed {logic [W-1:0] x, y;} fphub_pair_t; state enum {WAIT_X, WAIT_Y}.
- One sub-module, fphub_pair_fifo (parameterised DEPTH, data type fphub_pair_t, push/pop/full/empty/level).
- The adder is instantiated alongside, at top level, not inside this block.

## Test plan
- Reset then add: feed 0x3F800000, then 0x40000000 with in_sub=0, out_ready=1.
  - add_x/add_y = those words.
  - out_valid rises 2 cycles after the Y handshake.
  - out_z = adder Z for that pair.
- Subtract: the same pair with in_sub=1 gives add_y = 0xC0000000 and out_z = Z(X, −Y). in_sub sampled with an X word has no effect.
- Backpressure: out_ready=0, stream 2·DEPTH+3 words.
  - level reaches DEPTH; in_ready=0 only in WAIT_Y.
  - out_z holds its first result.
  - Release out_ready: DEPTH+1 results arrive in order, 1 per cycle.
- Simultaneous push/pop at level=2 with out_ready=1: level stays 2; pointer wrap is exercised past DEPTH pairs.
- Flush:
  - Flush in WAIT_Y with 3 pairs queued and out_valid=1: level→0, state→WAIT_X, in_ready=0 that cycle.
  - out_z is retained until out_ready.
  - The next word is treated as X.
- Async reset mid-stream: assert rst between edges. Outputs go to reset values before the next edge, and no spurious out_valid appears after release.

Source files
------------

// File: rtl/fphub_pkg.sv
// Shared types for the FPHUB operand pairing path: word width, the X/Y pair
// record held in the pair FIFO, and the pairing FSM state encoding.
package fphub_pkg;

  localparam int FP_M = 23;
  localparam int FP_E = 8;
  localparam int W    = FP_E + FP_M + 1;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } fphub_pair_t;

  typedef enum logic {
    WAIT_X = 1'b0,
    WAIT_Y = 1'b1
  } pair_state_t;

endpackage

// File: rtl/fphub_pair_issuer_if.sv
// Bundle of the pair issuer's stream, adder and status signals. The master
// side feeds words, the adder result and downstream ready; the slave is the issuer.
interface fphub_pair_issuer_if #(
  parameter int DEPTH = 4
);
  import fphub_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  // Both streams transfer a beat on a rising edge where valid & ready are high.
  // A producer holding valid keeps its payload stable until that edge; ready
  // never depends combinationally on the same stream's valid.
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_sub;
  logic [W-1:0]  add_x;
  logic [W-1:0]  add_y;
  logic [W-1:0]  add_z;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_z;
  logic [LW-1:0] level;
  pair_state_t   state;

  modport master (
    output flush, in_valid, in_data, in_sub, add_z, out_ready,
    input  in_ready, add_x, add_y, out_valid, out_z, level, state
  );

  modport slave (
    input  flush, in_valid, in_data, in_sub, add_z, out_ready,
    output in_ready, add_x, add_y, out_valid, out_z, level, state
  );

endinterface

// File: rtl/fphub_pair_fifo.sv
// Small circular buffer of X/Y operand pairs. Counters carry one extra MSB so
// full and empty are told apart by the occupancy difference alone.
module fphub_pair_fifo
  import fphub_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fphub_pair_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  T                         i_push_data,
  input  logic                     i_pop,
  output T                         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW:0]   r_wr_cnt;
  logic [AW:0]   r_rd_cnt;
  T              r_mem [DEPTH];

  logic [LW-1:0] w_level;
  logic          w_full;
  logic          w_empty;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_level   = r_wr_cnt - r_rd_cnt;
  assign w_full    = (w_level == LW'(DEPTH));
  assign w_empty   = (w_level == '0);
  // A same-cycle pop does not free a slot for the push: full blocks the push.
  assign w_do_push = i_push & ~w_full  & ~i_flush;
  assign w_do_pop  = i_pop  & ~w_empty & ~i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else if (i_flush) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_do_push) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_do_pop)  r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_cnt[AW-1:0]] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_cnt[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = w_level;

endmodule

// File: rtl/fphub_pair_issuer.sv
// Pairs a serial FPHUB word stream into X/Y operands (optionally negating Y),
// queues the pairs for the external adder and registers its result.
module fphub_pair_issuer
  import fphub_pkg::*;
#(
  parameter int M     = 23,
  parameter int E     = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fphub_pair_issuer_if.slave    bus
);

  localparam int SIGN_BIT = E + M;
  localparam int LW       = $clog2(DEPTH) + 1;

  pair_state_t   r_state;
  pair_state_t   w_state_nxt;
  logic [W-1:0]  r_x_hold;
  logic          r_out_valid;
  logic [W-1:0]  r_out_z;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_capture_x;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_level;
  fphub_pair_t   w_pair;
  fphub_pair_t   w_head;

  // Pairing FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_X;
    else     r_state <= w_state_nxt;
  end

  // Pairing FSM: next state. Flush always returns to expecting an X word.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = WAIT_X;
    end else if (w_accept) begin
      case (r_state)
        WAIT_X:  w_state_nxt = WAIT_Y;
        WAIT_Y:  w_state_nxt = WAIT_X;
        default: w_state_nxt = WAIT_X;
      endcase
    end
  end

  // Pairing FSM: outputs. An X word never needs a FIFO slot, so only WAIT_Y
  // backpressures; out_ready is deliberately absent from in_ready.
  always_comb begin
    w_in_ready  = ~bus.flush & ~((r_state == WAIT_Y) & w_full);
    w_accept    = bus.in_valid & w_in_ready;
    w_capture_x = w_accept & (r_state == WAIT_X);
    w_push      = w_accept & (r_state == WAIT_Y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_x_hold <= '0;
    else if (w_capture_x) r_x_hold <= bus.in_data;
  end

  // Subtraction is a plain sign-bit flip of Y; special values pass untouched.
  always_comb begin
    w_pair.x = r_x_hold;
    w_pair.y = bus.in_data ^ (W'(bus.in_sub) << SIGN_BIT);
  end

  fphub_pair_fifo #(
    .DEPTH (DEPTH),
    .T     (fphub_pair_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (bus.flush),
    .i_push      (w_push),
    .i_push_data (w_pair),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level)
  );

  assign w_pop = ~w_empty & (~r_out_valid | bus.out_ready) & ~bus.flush;

  // Result register survives flush so an already computed Z is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_z     <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_z     <= bus.add_z;
    end else if (r_out_valid & bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.add_x     = w_head.x;
  assign bus.add_y     = w_head.y;
  assign bus.out_valid = r_out_valid;
  assign bus.out_z     = r_out_z;
  assign bus.level     = w_level;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_fphub_pair_issuer.sv
// Directed bench for fphub_pair_issuer with an integer-add stand-in for the
// FPHUB adder so every expected Z is known from the operands alone.
module tb_fphub_pair_issuer;
  import fphub_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [W-1:0] exp_q[$];

  fphub_pair_issuer_if #(.DEPTH(DEPTH)) bus ();

  fphub_pair_issuer #(
    .M     (23),
    .E     (8),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Stand-in adder: combinational function of the FIFO head.
  assign bus.add_z = bus.add_x + bus.add_y;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;
  end

  function automatic logic [W-1:0] bp_word(input int i);
    return (W'(i + 1) << 24) | W'(i);
  endfunction

  // Driver: present one word (caller is at posedge+1), hold until accepted.
  task automatic send_word(input logic [W-1:0] d, input logic s);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sub   = s;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL send_timeout in_ready=%b required=1 data=%h", bus.in_ready, d);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sub   = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid actual=%b required=0", bus.out_valid); end
    total++; if (bus.out_z !== '0) begin bad++; $display("FAIL rst_out_z actual=%h required=0", bus.out_z); end
    total++; if (bus.level !== '0) begin bad++; $display("FAIL rst_level actual=%0d required=0", bus.level); end
    total++; if (bus.state !== WAIT_X) begin bad++; $display("FAIL rst_state actual=%0d required=%0d", bus.state, WAIT_X); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready actual=%b required=1", bus.in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    send_word(32'h3F80_0000, 1'b0);
    send_word(32'h4000_0000, 1'b0);
    @(negedge clk);
    total++; if (bus.add_x !== 32'h3F80_0000) begin bad++; $display("FAIL add_x actual=%h required=3f800000", bus.add_x); end
    total++; if (bus.add_y !== 32'h4000_0000) begin bad++; $display("FAIL add_y actual=%h required=40000000", bus.add_y); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid actual=%b required=0", bus.out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_valid actual=%b required=1", bus.out_valid); end
    total++; if (bus.out_z !== 32'h7F80_0000) begin bad++; $display("FAIL add_z actual=%h required=7f800000", bus.out_z); end
    total++; if (bus.level !== '0) begin bad++; $display("FAIL add_level actual=%0d required=0", bus.level); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_taken actual=%b required=0", bus.out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    bus.out_ready = 1'b1;
    send_word(32'h3F80_0000, 1'b1);
    send_word(32'h4000_0000, 1'b1);
    @(negedge clk);
    total++; if (bus.add_x !== 32'h3F80_0000) begin bad++; $display("FAIL sub_x_unflipped actual=%h required=3f800000", bus.add_x); end
    total++; if (bus.add_y !== 32'hC000_0000) begin bad++; $display("FAIL sub_y actual=%h required=c0000000", bus.add_y); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_z !== 32'hFF80_0000) begin
      bad++; $display("FAIL sub_z actual=%b/%h required=1/ff800000", bus.out_valid, bus.out_z);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 10; i++) send_word(bp_word(i), 1'b0);
    for (int p = 0; p < 5; p++) exp_q.push_back(bp_word(2*p) + bp_word(2*p + 1));
    @(negedge clk);
    total++; if (bus.level !== LW'(DEPTH)) begin bad++; $display("FAIL bp_full_level actual=%0d required=%0d", bus.level, DEPTH); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_wait_x actual=%b required=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b1 || bus.out_z !== exp_q[0]) begin
      bad++; $display("FAIL bp_hold actual=%b/%h required=1/%h", bus.out_valid, bus.out_z, exp_q[0]);
    end
    @(posedge clk); #1;
    send_word(bp_word(10), 1'b0);
    @(negedge clk);
    total++; if (bus.state !== WAIT_Y) begin bad++; $display("FAIL bp_state actual=%0d required=%0d", bus.state, WAIT_Y); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_wait_y actual=%b required=0", bus.in_ready); end
    total++; if (bus.out_z !== exp_q[0]) begin bad++; $display("FAIL bp_hold2 actual=%h required=%h", bus.out_z, exp_q[0]); end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int j = 0; j < DEPTH + 1; j++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1 || bus.out_z !== exp_q[0]) begin
        bad++; $display("FAIL bp_drain%0d actual=%b/%h required=1/%h", j, bus.out_valid, bus.out_z, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained actual=%b required=0", bus.out_valid); end
    @(posedge clk); #1;
    send_word(bp_word(11), 1'b0);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_tail_early actual=%b required=0", bus.out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_z !== bp_word(10) + bp_word(11)) begin
      bad++; $display("FAIL bp_tail actual=%b/%h required=1/%h", bus.out_valid, bus.out_z, bp_word(10) + bp_word(11));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] bx;
    logic [W-1:0] by;
    bus.out_ready = 1'b0;
    exp_q.delete();
    for (int p = 0; p < 3; p++) begin
      bx = 32'h2000_0000 + W'(p * 32'h11);
      by = 32'h0300_0000 + W'(p * 32'h101);
      send_word(bx, 1'b0);
      send_word(by, 1'b0);
      exp_q.push_back(bx + by);
    end
    @(negedge clk);
    total++; if (bus.level !== LW'(2)) begin bad++; $display("FAIL b2b_start_level actual=%0d required=2", bus.level); end
    @(posedge clk); #1;
    for (int p = 3; p < 8; p++) begin
      bx = 32'h2000_0000 + W'(p * 32'h11);
      by = 32'h0300_0000 + W'(p * 32'h101);
      send_word(bx, 1'b0);
      bus.out_ready = 1'b1;
      send_word(by, 1'b0);
      bus.out_ready = 1'b0;
      exp_q.push_back(bx + by);
      void'(exp_q.pop_front());
      @(negedge clk);
      total++; if (bus.level !== LW'(2)) begin bad++; $display("FAIL b2b_level%0d actual=%0d required=2", p, bus.level); end
      total++; if (bus.out_valid !== 1'b1 || bus.out_z !== exp_q[0]) begin
        bad++; $display("FAIL b2b_z%0d actual=%b/%h required=1/%h", p, bus.out_valid, bus.out_z, exp_q[0]);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1 || bus.out_z !== exp_q[0]) begin
        bad++; $display("FAIL b2b_drain%0d actual=%b/%h required=1/%h", j, bus.out_valid, bus.out_z, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0 || bus.level !== '0) begin
      bad++; $display("FAIL b2b_empty actual=%b/%0d required=0/0", bus.out_valid, bus.level);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [W-1:0] first_z;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_word(32'h0500_0000 + W'(i), 1'b0);
    first_z = 32'h0500_0000 + 32'h0500_0001;
    send_word(32'h0600_0000, 1'b0);
    @(negedge clk);
    total++; if (bus.level !== LW'(3) || bus.state !== WAIT_Y) begin
      bad++; $display("FAIL fl_setup actual=%0d/%0d required=3/%0d", bus.level, bus.state, WAIT_Y);
    end
    @(posedge clk); #1;
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h7777_7777;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fl_in_ready actual=%b required=0", bus.in_ready); end
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.level !== '0) begin bad++; $display("FAIL fl_level actual=%0d required=0", bus.level); end
    total++; if (bus.state !== WAIT_X) begin bad++; $display("FAIL fl_state actual=%0d required=%0d", bus.state, WAIT_X); end
    total++; if (bus.out_valid !== 1'b1 || bus.out_z !== first_z) begin
      bad++; $display("FAIL fl_kept actual=%b/%h required=1/%h", bus.out_valid, bus.out_z, first_z);
    end
    @(posedge clk); #1;
    send_word(32'h3F80_0000, 1'b0);
    send_word(32'h4000_0000, 1'b0);
    @(negedge clk);
    total++; if (bus.level !== LW'(1) || bus.add_x !== 32'h3F80_0000 || bus.add_y !== 32'h4000_0000) begin
      bad++; $display("FAIL fl_new_x actual=%0d/%h/%h required=1/3f800000/40000000", bus.level, bus.add_x, bus.add_y);
    end
    total++; if (bus.out_z !== first_z) begin bad++; $display("FAIL fl_kept2 actual=%h required=%h", bus.out_z, first_z); end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_z !== first_z) begin
      bad++; $display("FAIL fl_take1 actual=%b/%h required=1/%h", bus.out_valid, bus.out_z, first_z);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_z !== 32'h7F80_0000) begin
      bad++; $display("FAIL fl_take2 actual=%b/%h required=1/7f800000", bus.out_valid, bus.out_z);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_word(32'h0900_0000 + W'(i), 1'b0);
    @(negedge clk);
    total++; if (bus.level !== LW'(1) || bus.out_valid !== 1'b1 || bus.state !== WAIT_Y) begin
      bad++; $display("FAIL ar_setup actual=%0d/%b/%0d required=1/1/%0d", bus.level, bus.out_valid, bus.state, WAIT_Y);
    end
    @(posedge clk); #1;
    #1 rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_z !== '0) begin
      bad++; $display("FAIL ar_out actual=%b/%h required=0/0", bus.out_valid, bus.out_z);
    end
    total++; if (bus.level !== '0 || bus.state !== WAIT_X || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL ar_state actual=%0d/%0d/%b required=0/%0d/1", bus.level, bus.state, bus.in_ready, WAIT_X);
    end
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0 || bus.level !== '0) begin
        bad++; $display("FAIL ar_quiet%0d actual=%b/%0d required=0/0", j, bus.out_valid, bus.level);
      end
    end
    @(posedge clk); #1;
    send_word(32'h4000_0000, 1'b0);
    send_word(32'h3F80_0000, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_z !== 32'h4000_0000 + 32'hBF80_0000) begin
      bad++; $display("FAIL ar_after actual=%b/%h required=1/%h", bus.out_valid, bus.out_z, 32'h4000_0000 + 32'hBF80_0000);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog time=%0t required=finish", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
